// File: rtl/wb_burst_master_if.sv
// Command and Wishbone B3 bundle for wb_burst_master.
// master: the burst engine; slave: the command source plus the bus slave.
interface wb_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int LW = 8
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [aw-1:0]   cmd_adr_i;
  logic [LW-1:0]   cmd_len_i;
  logic [1:0]      cmd_bte_i;
  logic [dw-1:0]   cmd_seed_i;
  logic [aw-1:0]   wb_adr_o;
  logic [dw-1:0]   wb_dat_o;
  logic [dw/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic [dw-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            wb_rty_i;
  logic            done_o;
  logic            bus_err_o;
  logic [LW:0]     mism_cnt_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i,
    input  cmd_len_i, cmd_bte_i, cmd_seed_i,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_ready_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    output wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output done_o, bus_err_o, mism_cnt_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i,
    output cmd_len_i, cmd_bte_i, cmd_seed_i,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_ready_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    input  wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  done_o, bus_err_o, mism_cnt_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one valid/ready command -> one CTI/BTE cycle.
// Ports: wb_clk_i, wb_rst_n_i (async low), bus (wb_burst_master_if.master):
//   cmd_* command in, wb_* bus, done_o / bus_err_o / mism_cnt_o status.
// Writes send seed+k on beat k; reads compare against the same pattern.
// Option: WB_BURST_MASTER_TIMEOUT_EN adds an ack watchdog of TIMEOUT cycles.
module wb_burst_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int LW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  wb_burst_master_if.master bus
);

  localparam int            BS   = $clog2(dw/8);
  localparam logic [aw-1:0] STEP = aw'(dw/8);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_BUS,
    S_RETRY,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic          we_q;
  logic [aw-1:0] adr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_q;
  logic [1:0]    bte_q;
  logic [dw-1:0] seed_q;
  logic          berr_q;
  logic [LW:0]   mism_q;

  logic          in_bus;
  logic          accept;
  logic          last;
  logic          hit_err;
  logic          hit_rty;
  logic          hit_ack;
  logic          tmo;
  logic          abort;
  logic [dw-1:0] pat;
  logic [aw-1:0] wrap_msk;
  logic [aw-1:0] adr_inc;
  logic [aw-1:0] adr_nx;

  assign in_bus  = state == S_BUS;
  assign accept  = (state == S_IDLE) && bus.cmd_valid_i;
  assign last    = beat_q == len_q;
  // err beats rty beats ack
  assign hit_err = in_bus && bus.wb_err_i;
  assign hit_rty = in_bus && bus.wb_rty_i && !bus.wb_err_i;
  assign hit_ack = in_bus && bus.wb_ack_i
                 && !bus.wb_err_i && !bus.wb_rty_i;
  assign abort   = hit_err || tmo;
  assign pat     = seed_q + dw'(beat_q);

  // Bits covered by the mask step; the rest hold (wrap bursts).
  always_comb begin
    wrap_msk = '1;
    unique case (bte_q)
      2'b01:   wrap_msk = aw'(3) << BS;
      2'b10:   wrap_msk = aw'(7) << BS;
      2'b11:   wrap_msk = aw'(15) << BS;
      default: wrap_msk = '1;
    endcase
  end

  assign adr_inc = adr_q + STEP;
  assign adr_nx  = (adr_q & ~wrap_msk) | (adr_inc & wrap_msk);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          quiet;

  assign quiet = in_bus && !bus.wb_ack_i
               && !bus.wb_err_i && !bus.wb_rty_i;
  assign tmo   = quiet && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt <= '0;
    end else if (accept || (in_bus && !quiet)) begin
      tmo_cnt <= '0;
    end else if (quiet) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= S_RST;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.cmd_ready_o = 1'b0;
    bus.wb_cyc_o    = 1'b0;
    bus.wb_stb_o    = 1'b0;
    bus.wb_we_o     = 1'b0;
    bus.wb_adr_o    = '0;
    bus.wb_dat_o    = '0;
    bus.wb_cti_o    = 3'b000;
    bus.wb_bte_o    = 2'b00;
    bus.done_o      = 1'b0;
    unique case (state)
      S_RST: state_nx = S_IDLE;
      S_IDLE: begin
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i) state_nx = S_BUS;
      end
      S_BUS: begin
        bus.wb_cyc_o = 1'b1;
        bus.wb_stb_o = 1'b1;
        bus.wb_we_o  = we_q;
        bus.wb_adr_o = adr_q;
        bus.wb_dat_o = we_q ? pat : '0;
        bus.wb_bte_o = bte_q;
        if (len_q == '0) bus.wb_cti_o = 3'b000;
        else if (last)   bus.wb_cti_o = 3'b111;
        else             bus.wb_cti_o = 3'b010;
        if (abort)                state_nx = S_DONE;
        else if (hit_rty)         state_nx = S_RETRY;
        else if (hit_ack && last) state_nx = S_DONE;
      end
      S_RETRY: state_nx = S_BUS;
      S_DONE: begin
        bus.done_o = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      we_q   <= 1'b0;
      adr_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      bte_q  <= 2'b00;
      seed_q <= '0;
      berr_q <= 1'b0;
      mism_q <= '0;
    end else if (accept) begin
      we_q   <= bus.cmd_we_i;
      adr_q  <= bus.cmd_adr_i;
      len_q  <= bus.cmd_len_i;
      beat_q <= '0;
      bte_q  <= bus.cmd_bte_i;
      seed_q <= bus.cmd_seed_i;
      berr_q <= 1'b0;
      mism_q <= '0;
    end else begin
      if (abort) berr_q <= 1'b1;
      if (hit_ack) begin
        beat_q <= beat_q + 1'b1;
        adr_q  <= adr_nx;
        if (!we_q && bus.wb_dat_i != pat && mism_q != '1)
          mism_q <= mism_q + 1'b1;
      end
    end
  end

  assign bus.wb_sel_o   = '1;
  assign bus.bus_err_o  = berr_q;
  assign bus.mism_cnt_o = mism_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: vector table, directed corner cases and
// randomized write/read-back pairs against an address/pattern model.
module tb_wb_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_burst_master_if #(.dw(DW), .aw(AW), .LW(LW)) b ();

  wb_burst_master #(
    .dw(DW), .aw(AW), .LW(LW), .TIMEOUT(64)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (b)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
  } xfer_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  len;
    logic [1:0]  bte;
    logic [31:0] seed;
    int          eb;
    int          rb;
    int          acks;
    logic        berr;
    logic [31:0] last_adr;
    logic [2:0]  last_cti;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int delay_max = 0;
  int err_beat  = -1;
  int rty_beat  = -1;
  bit no_ack    = 0;
  bit junk      = 0;
  bit rty_once  = 0;
  int beat_idx  = 0;
  int wait_cnt  = 0;
  int cur_delay = 0;
  int n_err     = 0;
  logic [31:0] rty_adr, rty_dat;
  logic [2:0]  rty_cti;

  logic [31:0] mem    [logic [31:0]];
  logic [31:0] refmem [logic [31:0]];
  xfer_t log_q[$];
  bit cyc_tr[$];
  bit done_tr[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i]);
    return n;
  endfunction

  function automatic int first_one(input bit q[$]);
    foreach (q[i]) if (q[i]) return i;
    return -100;
  endfunction

  // Beat k address from the burst rules, not from the RTL masking.
  function automatic logic [31:0] beat_adr(input logic [31:0] a,
                                           input int k,
                                           input logic [1:0] bte);
    int n, w;
    logic [31:0] span;
    if (bte == 2'd0) return a + 32'(4 * k);
    n    = (bte == 2'd1) ? 4 : (bte == 2'd2) ? 8 : 16;
    span = 32'(4 * n);
    w    = int'((a >> 2) % 32'(n));
    return (a & ~(span - 1)) + 32'(((w + k) % n) * 4);
  endfunction

  function automatic logic [2:0] exp_cti(input int len, input int k);
    if (len == 0) return 3'b000;
    return (k == len) ? 3'b111 : 3'b010;
  endfunction

  // Slave: samples DUT outputs 1 time unit after each edge.
  initial begin
    b.wb_ack_i = 1'b0;
    b.wb_err_i = 1'b0;
    b.wb_rty_i = 1'b0;
    b.wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc_tr.push_back(b.wb_cyc_o);
      done_tr.push_back(b.done_o);
      b.wb_ack_i = 1'b0;
      b.wb_err_i = 1'b0;
      b.wb_rty_i = 1'b0;
      b.wb_dat_i = '0;
      if (b.wb_cyc_o && b.wb_stb_o) begin
        if (wait_cnt < cur_delay) begin
          wait_cnt++;
        end else if (beat_idx == err_beat) begin
          b.wb_err_i = 1'b1;
          b.wb_rty_i = 1'b1;
          b.wb_ack_i = 1'b1;
          n_err++;
        end else if (beat_idx == rty_beat && !rty_once) begin
          b.wb_rty_i = 1'b1;
          b.wb_ack_i = 1'b1;
          rty_once   = 1'b1;
          rty_adr    = b.wb_adr_o;
          rty_dat    = b.wb_dat_o;
          rty_cti    = b.wb_cti_o;
        end else if (!no_ack) begin
          b.wb_ack_i = 1'b1;
          if (b.wb_we_o) mem[b.wb_adr_o] = b.wb_dat_o;
          else if (mem.exists(b.wb_adr_o)) b.wb_dat_i = mem[b.wb_adr_o];
          log_q.push_back('{b.wb_adr_o, b.wb_dat_o, b.wb_cti_o,
                            b.wb_bte_o, b.wb_we_o});
          beat_idx++;
          wait_cnt  = 0;
          cur_delay = $urandom_range(0, delay_max);
        end
      end else if (junk) begin
        b.wb_ack_i = ($urandom_range(0, 3) == 0);
        b.wb_err_i = ($urandom_range(0, 3) == 0);
        b.wb_rty_i = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic run_cmd(input logic we, input logic [31:0] adr,
                         input logic [7:0] len, input logic [1:0] bte,
                         input logic [31:0] seed, output bit gd,
                         output logic berr, output logic [8:0] mism);
    int n;
    log_q.delete();
    cyc_tr.delete();
    done_tr.delete();
    beat_idx  = 0;
    wait_cnt  = 0;
    cur_delay = $urandom_range(0, delay_max);
    rty_once  = 0;
    n_err     = 0;
    b.cmd_we_i    = we;
    b.cmd_adr_i   = adr;
    b.cmd_len_i   = len;
    b.cmd_bte_i   = bte;
    b.cmd_seed_i  = seed;
    b.cmd_valid_i = 1'b1;
    n = 0;
    while (!b.cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    chk("handshake_ready", b.cmd_ready_o, 1);
    step();
    b.cmd_valid_i = 1'b0;
    n = 0;
    while (!b.done_o && n < 3000) begin
      step();
      n++;
    end
    gd   = b.done_o;
    berr = b.bus_err_o;
    mism = b.mism_cnt_o;
    chk("done_seen", gd, 1);
    chk("ready_low_in_done", b.cmd_ready_o, 0);
    step();
    chk("ready_after_done", b.cmd_ready_o, 1);
  endtask

  task automatic check_beats(input string nm, input logic we,
                             input logic [31:0] a, input int len,
                             input logic [1:0] bte,
                             input logic [31:0] seed);
    chk({nm, "_nbeats"}, log_q.size(), len + 1);
    for (int k = 0; k <= len && k < log_q.size(); k++) begin
      chk({nm, "_adr"}, log_q[k].adr, beat_adr(a, k, bte));
      if (we) chk({nm, "_dat"}, log_q[k].dat, seed + 32'(k));
      chk({nm, "_cti"}, log_q[k].cti, exp_cti(len, k));
      chk({nm, "_bte"}, log_q[k].bte, bte);
      chk({nm, "_we"}, log_q[k].we, we);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    vec_t        vt[9];
    bit          gd;
    logic        berr;
    logic [8:0]  mism;
    int          f, d, em;
    logic [31:0] a, s, ca, v;
    logic [7:0]  ln;
    logic [1:0]  bt;

    vt[0] = '{1'b1, 32'h400, 8'd0, 2'd0, 32'h1,
              -1, -1, 1, 1'b0, 32'h400, 3'b000};
    vt[1] = '{1'b1, 32'h40C, 8'd3, 2'd1, 32'h10,
              -1, -1, 4, 1'b0, 32'h408, 3'b111};
    vt[2] = '{1'b1, 32'h41C, 8'd7, 2'd2, 32'h20,
              -1, -1, 8, 1'b0, 32'h418, 3'b111};
    vt[3] = '{1'b1, 32'h43C, 8'd15, 2'd3, 32'h30,
              -1, -1, 16, 1'b0, 32'h438, 3'b111};
    vt[4] = '{1'b1, 32'h500, 8'd5, 2'd0, 32'h40,
              3, -1, 3, 1'b1, 32'h508, 3'b010};
    vt[5] = '{1'b0, 32'h600, 8'd2, 2'd0, 32'h50,
              -1, 2, 3, 1'b0, 32'h608, 3'b111};
    vt[6] = '{1'b1, 32'h704, 8'd7, 2'd1, 32'h60,
              -1, -1, 8, 1'b0, 32'h700, 3'b111};
    vt[7] = '{1'b1, 32'h1000, 8'd255, 2'd0, 32'h70,
              -1, -1, 256, 1'b0, 32'h13FC, 3'b111};
    vt[8] = '{1'b1, 32'h800, 8'd4, 2'd0, 32'h80,
              0, -1, 0, 1'b1, 32'h0, 3'b000};

    b.cmd_valid_i = 1'b0;
    b.cmd_we_i    = 1'b0;
    b.cmd_adr_i   = '0;
    b.cmd_len_i   = '0;
    b.cmd_bte_i   = '0;
    b.cmd_seed_i  = '0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cyc", b.wb_cyc_o, 0);
    chk("rst_stb", b.wb_stb_o, 0);
    chk("rst_ready", b.cmd_ready_o, 0);
    chk("rst_adr", b.wb_adr_o, 0);
    chk("rst_cti", b.wb_cti_o, 0);
    chk("rst_done", b.done_o, 0);
    chk("rst_berr", b.bus_err_o, 0);
    chk("rst_mism", b.mism_cnt_o, 0);
    #29 rst_n = 1'b1;
    #1 chk("ready_before_edge", b.cmd_ready_o, 0);
    step();
    chk("ready_first_edge", b.cmd_ready_o, 1);

    // Linear write, ack every cycle
    run_cmd(1'b1, 32'h100, 8'd3, 2'd0, 32'hA0, gd, berr, mism);
    check_beats("t1", 1'b1, 32'h100, 3, 2'd0, 32'hA0);
    chk("t1_adr3", log_q[3].adr, 32'h10C);
    chk("t1_dat3", log_q[3].dat, 32'hA3);
    chk("t1_berr", berr, 0);
    chk("t1_done_once", ones(done_tr), 1);
    d = first_one(done_tr);
    chk("t1_cyc_before_done", cyc_tr[d - 1], 1);
    chk("t1_cyc_at_done", cyc_tr[d], 0);

    // Read-back with delays and one corrupted word
    delay_max = 4;
    mem[32'h108] = 32'h0;
    run_cmd(1'b0, 32'h100, 8'd3, 2'd0, 32'hA0, gd, berr, mism);
    check_beats("t2", 1'b0, 32'h100, 3, 2'd0, 32'hA0);
    chk("t2_mism", mism, 1);
    chk("t2_berr", berr, 0);
    chk("t2_done_once", ones(done_tr), 1);
    step();
    chk("t2_mism_held", b.mism_cnt_o, 1);
    delay_max = 0;

    // Wrap4
    run_cmd(1'b1, 32'h208, 8'd3, 2'd1, 32'h7, gd, berr, mism);
    check_beats("t3", 1'b1, 32'h208, 3, 2'd1, 32'h7);
    chk("t3_adr2", log_q[2].adr, 32'h200);

    // err on beat 1 of an 8-beat write
    err_beat = 1;
    run_cmd(1'b1, 32'h900, 8'd7, 2'd0, 32'h1, gd, berr, mism);
    chk("t4_acks", log_q.size(), 1);
    chk("t4_berr", berr, 1);
    chk("t4_stb_cycles", ones(cyc_tr), 2);
    err_beat = -1;

    // rty on beat 0
    rty_beat = 0;
    run_cmd(1'b1, 32'h300, 8'd1, 2'd0, 32'h5, gd, berr, mism);
    f = first_one(cyc_tr);
    chk("t5_gap", cyc_tr[f + 1], 0);
    chk("t5_reissue", cyc_tr[f + 2], 1);
    chk("t5_stb_cycles", ones(cyc_tr), 3);
    chk("t5_rty_adr", rty_adr, 32'h300);
    chk("t5_rty_dat", rty_dat, 32'h5);
    chk("t5_rty_cti", rty_cti, 3'b010);
    check_beats("t5", 1'b1, 32'h300, 1, 2'd0, 32'h5);
    chk("t5_berr", berr, 0);
    rty_beat = -1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      err_beat = vt[i].eb;
      rty_beat = vt[i].rb;
      run_cmd(vt[i].we, vt[i].adr, vt[i].len, vt[i].bte, vt[i].seed,
              gd, berr, mism);
      chk($sformatf("vec%0d_acks", i), log_q.size(), vt[i].acks);
      chk($sformatf("vec%0d_berr", i), berr, vt[i].berr);
      if (vt[i].acks > 0) begin
        chk($sformatf("vec%0d_last_adr", i), log_q[$].adr,
            vt[i].last_adr);
        chk($sformatf("vec%0d_last_cti", i), log_q[$].cti,
            vt[i].last_cti);
      end
    end
    err_beat = -1;
    rty_beat = -1;

    // Reset mid-burst
    b.cmd_we_i    = 1'b1;
    b.cmd_adr_i   = 32'h2000;
    b.cmd_len_i   = 8'd20;
    b.cmd_bte_i   = 2'd0;
    b.cmd_seed_i  = 32'h0;
    b.cmd_valid_i = 1'b1;
    step();
    b.cmd_valid_i = 1'b0;
    step();
    step();
    chk("t6_cyc_pre", b.wb_cyc_o, 1);
    done_tr.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cyc_async", b.wb_cyc_o, 0);
    chk("t6_stb_async", b.wb_stb_o, 0);
    step();
    step();
    #3 rst_n = 1'b1;
    #1 chk("t6_ready_pre_edge", b.cmd_ready_o, 0);
    step();
    chk("t6_ready_post", b.cmd_ready_o, 1);
    step();
    step();
    chk("t6_no_done", ones(done_tr), 0);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    no_ack = 1;
    run_cmd(1'b1, 32'h3000, 8'd3, 2'd0, 32'h1, gd, berr, mism);
    chk("tmo_berr", berr, 1);
    chk("tmo_latency", first_one(done_tr) - first_one(cyc_tr), 64);
    no_ack = 0;
`endif

    // Random write / read-back pairs against the model
    junk = 1;
    for (int t = 0; t < 30; t++) begin
      a  = 32'h8000 + (32'($urandom_range(0, 255)) << 2);
      ln = 8'($urandom_range(0, 20));
      bt = 2'($urandom_range(0, 3));
      s  = $urandom;
      delay_max = $urandom_range(0, 3);
      run_cmd(1'b1, a, ln, bt, s, gd, berr, mism);
      check_beats("rnd_wr", 1'b1, a, int'(ln), bt, s);
      chk("rnd_wr_berr", berr, 0);
      for (int k = 0; k <= int'(ln); k++)
        refmem[beat_adr(a, k, bt)] = s + 32'(k);
      if ($urandom_range(0, 1) == 1) begin
        ca = beat_adr(a, $urandom_range(0, int'(ln)), bt);
        v  = $urandom;
        refmem[ca] = v;
        mem[ca]    = v;
      end
      em = 0;
      for (int k = 0; k <= int'(ln); k++)
        if (refmem[beat_adr(a, k, bt)] != s + 32'(k)) em++;
      run_cmd(1'b0, a, ln, bt, s, gd, berr, mism);
      check_beats("rnd_rd", 1'b0, a, int'(ln), bt, s);
      chk("rnd_rd_mism", mism, em);
      chk("rnd_rd_berr", berr, 0);
    end
    junk = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
